// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scanner.
package seg_disp_pkg;

    localparam int NUM_DIGITS_DEF = 8;
    localparam int TICK_DIV_DEF   = 100000;
    localparam int MAX_DIGITS     = 16;

    localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = {MAX_DIGITS{1'b1}};

    // Index of the most-significant nonzero nibble; 0 when the word is zero.
    function automatic logic [3:0] msd_index(input logic [4*MAX_DIGITS-1:0] word);
        logic [3:0] msd;
        msd = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (word[4*i +: 4] != 4'h0) begin
                msd = 4'(i);
            end else begin
                msd = msd;
            end
        end
        return msd;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell prescaler: tick_o is high for one cycle every TICK_DIV clocks,
// in the cycle where the count sits at TICK_DIV-1.
module scan_tick_gen
    import seg_disp_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    localparam int CNT_W   = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    // Next prescaler value with wrap at TICK_DIV-1.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Tick is registered so it lines up with the count reaching its maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_MAX);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner with pending/shadow buffering so words change only at frame start.
// Optional build macro LEAD_ZERO_BLANK_EN turns off digits above the most-significant nonzero nibble.
module seg_scan_driver
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    localparam int DATA_W    = 4 * NUM_DIGITS,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  blank,
    output logic [3:0]            hex_out,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ALL_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic                  tick_s;
    logic                  wrap_tick_s;
    logic                  lit_s;

    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [DATA_W-1:0]     shadow_q,  shadow_d;
    logic [DATA_W-1:0]     pending_q, pending_d;
    logic                  ready_q,   ready_d;
    logic [3:0]            hex_q,     hex_d;
    logic [NUM_DIGITS-1:0] an_q,      an_d;
    logic                  frame_q;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_s)
    );

    assign wrap_tick_s = tick_s && (idx_q == IDX_LAST);

    // Next digit, buffer handshake and the output values derived from the new index/shadow.
    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ready_d   = ready_q;

        if (tick_s) begin
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        // ready_q low means the pending slot is full; it can only drain on a wrap-tick.
        if (wrap_tick_s && !ready_q) begin
            shadow_d = pending_q;
            ready_d  = 1'b1;
        end else if (data_valid && ready_q) begin
            pending_d = data_in;
            ready_d   = 1'b0;
        end else begin
            ready_d = ready_q;
        end

        hex_d = shadow_d[{idx_d, 2'b00} +: 4];

`ifdef LEAD_ZERO_BLANK_EN
        lit_s = (4'(idx_d) <= msd_index((4*MAX_DIGITS)'(shadow_d)));
`else
        lit_s = 1'b1;
`endif

        if (blank || !lit_s) begin
            an_d = AN_OFF;
        end else begin
            an_d = ~(AN_ONE << idx_d);
        end
    end

    // State and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= {IDX_W{1'b0}};
            shadow_q  <= {DATA_W{1'b0}};
            pending_q <= {DATA_W{1'b0}};
            ready_q   <= 1'b1;
            hex_q     <= 4'h0;
            an_q      <= AN_OFF;
            frame_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            hex_q     <= hex_d;
            an_q      <= an_d;
            frame_q   <= wrap_tick_s;
        end
    end

    assign data_ready = ready_q;
    assign hex_out    = hex_q;
    assign an_n       = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_q;

endmodule
